// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring long-divider: controller state
// encoding and sizing of the optional cycle counter (DIVCTRL_PERF_EN).
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CHECK,
    ALIGN,
    COMP,
    SHIFT,
    DONE
  } state_t;

  // Worst case is 4 + 3*(SIZE-1) busy cycles; the counter is sized with margin.
  localparam int PERF_CYC_PER_BIT = 4;
  localparam int PERF_CYC_FIXED   = 8;

  function automatic int perf_width(input int size);
    return $clog2(PERF_CYC_PER_BIT * size + PERF_CYC_FIXED);
  endfunction

endpackage

// File: rtl/divider_ctrl_if.sv
// Controller bundle: system handshake, datapath status and datapath control.
// last_cycles exists only when DIVCTRL_PERF_EN is defined.
interface divider_ctrl_if
  import divider_pkg::*;
#(
  parameter int SIZE = 32
);

  logic start;
  logic busy;
  logic done;
  logic div_by_zero;

  logic cnt_is_0;
  logic divisor_is_0;
  logic dvsr_le_rem;
  logic shifted_divisor_MSB;

  logic init;
  logic left;
  logic right;
  logic sub;
  logic q_shift;
  logic q_bit;

`ifdef DIVCTRL_PERF_EN
  logic [perf_width(SIZE)-1:0] last_cycles;
`endif

  // master: wrapper/datapath side; slave: the controller
  modport master (
`ifdef DIVCTRL_PERF_EN
    input  last_cycles,
`endif
    output start, cnt_is_0, divisor_is_0, dvsr_le_rem, shifted_divisor_MSB,
    input  busy, done, div_by_zero, init, left, right, sub, q_shift, q_bit
  );

  modport slave (
`ifdef DIVCTRL_PERF_EN
    output last_cycles,
`endif
    input  start, cnt_is_0, divisor_is_0, dvsr_le_rem, shifted_divisor_MSB,
    output busy, done, div_by_zero, init, left, right, sub, q_shift, q_bit
  );

endinterface

// File: rtl/divider_ctrl.sv
// Restoring long-division controller: sequences init/align/compare/shift and
// provides start/busy/done. Define DIVCTRL_PERF_EN to add the last_cycles counter.
module divider_ctrl
  import divider_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic          clk,
  input  logic          reset,
  divider_ctrl_if.slave bus
);

  if (SIZE < 2 || perf_width(SIZE) < 1) begin : g_size_chk
    $error("divider_ctrl: SIZE must be at least 2");
  end

  state_t state;
  logic   busy_q;
  logic   done_q;
  logic   dbz_q;
  logic   finish;
  logic   align_more;

  assign align_more = bus.dvsr_le_rem && !bus.shifted_divisor_MSB;
  assign finish     = (state == CHECK && bus.divisor_is_0) ||
                      (state == COMP  && bus.cnt_is_0);

  // NOTE: state and status flags are written with non-blocking assignments so
  // every read in this block sees the pre-edge value, independent of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= INIT;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
          end
        end
        INIT:  state <= CHECK;
        CHECK: state <= bus.divisor_is_0 ? DONE : ALIGN;
        ALIGN: if (!align_more) state <= COMP;
        COMP:  state <= bus.cnt_is_0 ? DONE : SHIFT;
        SHIFT: state <= COMP;
        default: state <= IDLE;
      endcase

      if (finish) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        dbz_q  <= (state == CHECK);
      end
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bus.init    = 1'b0;
    bus.left    = 1'b0;
    bus.right   = 1'b0;
    bus.sub     = 1'b0;
    bus.q_shift = 1'b0;
    bus.q_bit   = 1'b0;
    unique case (state)
      INIT:  bus.init = 1'b1;
      ALIGN: bus.left = align_more;
      COMP: begin
        bus.q_shift = 1'b1;
        bus.q_bit   = bus.dvsr_le_rem;
        bus.sub     = bus.dvsr_le_rem;
      end
      SHIFT:   bus.right = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

`ifdef DIVCTRL_PERF_EN
  localparam int CNT_W = perf_width(SIZE);

  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] last_cycles_q;

  // run_cnt is 0 in INIT, so run_cnt+1 on the final busy cycle is the total.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt       <= '0;
      last_cycles_q <= '0;
    end else if (busy_q) begin
      run_cnt <= run_cnt + 1'b1;
      if (finish) last_cycles_q <= run_cnt + 1'b1;
    end else begin
      run_cnt <= '0;
    end
  end

  assign bus.last_cycles = last_cycles_q;
`endif

endmodule

// File: tb/tb_divider_ctrl.sv
// Bench for divider_ctrl (SIZE=8) with a behavioural restoring-divider datapath
// and a scoreboard of expected results per division.
module tb_divider_ctrl;

  localparam int SIZE = 8;

  typedef struct {
    logic [7:0] quo;
    logic [7:0] rem;
    bit         dbz;
    int         done_cyc;
    int         lefts;
    int         subs;
    int         qshifts;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  divider_ctrl_if #(.SIZE(SIZE)) bus ();

  divider_ctrl #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // behavioural datapath
  logic [7:0] dividend = '0;
  logic [7:0] divisor  = '0;
  logic [7:0] rem_m    = '0;
  logic [7:0] dvsr_m   = '0;
  logic [7:0] quo_m    = '0;
  logic [3:0] cnt_m    = '0;

  assign bus.cnt_is_0            = (cnt_m == 4'd0);
  assign bus.divisor_is_0        = (dvsr_m == 8'd0);
  assign bus.dvsr_le_rem         = (dvsr_m <= rem_m);
  assign bus.shifted_divisor_MSB = dvsr_m[7];

  always @(posedge clk) begin
    if (bus.init) begin
      rem_m  <= dividend;
      dvsr_m <= divisor;
      cnt_m  <= '0;
      quo_m  <= '0;
    end else begin
      if (bus.left)  begin dvsr_m <= dvsr_m << 1; cnt_m <= cnt_m + 4'd1; end
      if (bus.right) begin dvsr_m <= dvsr_m >> 1; cnt_m <= cnt_m - 4'd1; end
      if (bus.sub)     rem_m <= rem_m - dvsr_m;
      if (bus.q_shift) quo_m <= {quo_m[6:0], bus.q_bit};
    end
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic [7:0] a, input logic [7:0] b);
    exp_t       e;
    logic [7:0] d;
    int         k;
    e.dbz = (b == 8'd0);
    if (e.dbz) begin
      e.quo = '0; e.rem = '0; e.done_cyc = 3;
      e.lefts = 0; e.subs = 0; e.qshifts = 0;
    end else begin
      d = b;
      k = 0;
      while (d <= a && !d[7]) begin
        d = d << 1;
        k++;
      end
      e.quo      = a / b;
      e.rem      = a % b;
      e.done_cyc = 5 + 3 * k;
      e.lefts    = k;
      e.subs     = $countones(e.quo);
      e.qshifts  = k + 1;
    end
    return e;
  endfunction

  task automatic run_div(input string name, input logic [7:0] a, input logic [7:0] b,
                         input bit busy_start, input int reset_at);
    exp_t       e;
    int         cyc = 0, lefts = 0, rights = 0, subs = 0, qshifts = 0;
    int         init_cyc = -1, done_cyc = -1, viol = 0;
    logic [7:0] qv = '0;
    bit         got_done = 0, aborted = 0;

    sb.push_back(make_exp(a, b));
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    bus.start = 1'b1;
    while (!got_done && !aborted && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.start = busy_start && cyc >= 3 && cyc <= 10;
      if (reset_at > 0 && cyc == reset_at + 1) begin
        check({name, " post_reset_outputs"},
              {bus.init, bus.left, bus.right, bus.sub, bus.q_shift, bus.q_bit,
               bus.busy, bus.done, bus.div_by_zero}, 0);
        reset   = 1'b0;
        aborted = 1;
      end else begin
        reset = (reset_at > 0 && cyc == reset_at);
        if (cyc == 1) begin
          check({name, " done_clear_in_init"}, {bus.done, bus.div_by_zero}, 0);
          check({name, " busy_in_init"}, bus.busy, 1);
        end
        if (bus.init && init_cyc < 0) init_cyc = cyc;
        if (bus.left)  lefts++;
        if (bus.right) rights++;
        if (bus.sub)   subs++;
        if (bus.q_shift) begin
          qshifts++;
          qv = {qv[6:0], bus.q_bit};
        end
        if (int'(bus.init) + int'(bus.left) + int'(bus.right) + int'(bus.sub) > 1) viol++;
        if (bus.sub && !bus.q_shift) viol++;
        if (bus.done) begin
          got_done = 1;
          done_cyc = cyc;
        end
      end
    end

    e = sb.pop_front();
    if (aborted) return;

    check({name, " done_seen"}, got_done, 1);
    check({name, " init_cycle"}, init_cyc, 1);
    check({name, " done_cycle"}, done_cyc, e.done_cyc);
    check({name, " div_by_zero"}, bus.div_by_zero, e.dbz);
    check({name, " left_pulses"}, lefts, e.lefts);
    check({name, " right_pulses"}, rights, e.lefts);
    check({name, " sub_pulses"}, subs, e.subs);
    check({name, " q_shift_pulses"}, qshifts, e.qshifts);
    check({name, " one_hot"}, viol, 0);
    if (!e.dbz) begin
      check({name, " q_bit_seq"}, qv, e.quo);
      check({name, " quotient"}, quo_m, e.quo);
      check({name, " remainder"}, rem_m, e.rem);
    end
`ifdef DIVCTRL_PERF_EN
    check({name, " last_cycles"}, bus.last_cycles, e.done_cyc - 1);
`endif
    @(negedge clk);
    check({name, " done_held"}, {bus.done, bus.busy, bus.div_by_zero}, {1'b1, 1'b0, e.dbz});
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state",
          {bus.init, bus.left, bus.right, bus.sub, bus.q_shift, bus.q_bit,
           bus.busy, bus.done, bus.div_by_zero}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_not_busy", bus.busy, 0);

    run_div("d100_7",        8'd100, 8'd7,   0, 0);
    run_div("d55_0",         8'd55,  8'd0,   0, 0);
    run_div("d5_9",          8'd5,   8'd9,   0, 0);
    run_div("dff_80",        8'hFF,  8'h80,  0, 0);
    run_div("d100_7_busy",   8'd100, 8'd7,   1, 0);
    run_div("d20_3_restart", 8'd20,  8'd3,   0, 0);
    run_div("d100_7_reset",  8'd100, 8'd7,   0, 6);
    run_div("d100_7_after",  8'd100, 8'd7,   0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
